// File: rtl/gate_arb_pkg.sv
// Shared types and helpers for the gate-unit round-robin arbiter.
package gate_arb_pkg;

  localparam int NREQ = 4;
  localparam int ID_W = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  function automatic logic [NREQ-1:0] onehot4(input logic [ID_W-1:0] id);
    onehot4 = 4'b0001 << id;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Rotating priority encoder: first set request bit starting at ptr, wrapping mod 4.
module rr_priority_pick
  import gate_arb_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] ptr,
  output logic [ID_W-1:0] winner,
  output logic            any
);

  logic [NREQ-1:0] rot;

  // rot[k] is the request that sits k positions after ptr
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_rot
    assign rot[gi] = req[ptr + ID_W'(gi)];
  end

  always_comb begin
    winner = ptr;
    any    = |rot;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        winner = ptr + ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/gate_unit_rr_arbiter.sv
// Round-robin arbiter sharing one 4-input gate unit among 4 requesters.
// Optional GATE_ARB_BACK_TO_BACK_EN removes the idle bubble between grants.
module gate_unit_rr_arbiter
  import gate_arb_pkg::*;
#(
  parameter int NREQ        = 4,
  parameter int HOLD_CYCLES = 2
)
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  output logic [3:0] grant,
  output logic [1:0] grant_id,
  output logic       grant_val,
  output logic       done
);

  if (NREQ != gate_arb_pkg::NREQ) begin : g_bad_nreq
    $error("gate_unit_rr_arbiter: NREQ must be 4");
  end
  if (HOLD_CYCLES < 1 || HOLD_CYCLES > 15) begin : g_bad_hold
    $error("gate_unit_rr_arbiter: HOLD_CYCLES must be 1..15");
  end

  localparam logic [3:0] CNT_LOAD = 4'(HOLD_CYCLES - 1);

  state_t    state_reg, state_next;
  logic [1:0] owner_reg, owner_next;
  logic [1:0] ptr_reg, ptr_next;
  logic [3:0] cnt_reg, cnt_next;

  logic [3:0] pick_req;
  logic [1:0] pick_ptr;
  logic [1:0] pick_winner;
  logic       pick_any;
  logic       owner_req;
  logic       grant_end;

  assign owner_req = req[owner_reg];
  assign grant_end = (state_reg == GRANT) && (!owner_req || (cnt_reg == 4'd0));

  // In GRANT the search is the back-to-back one: skip the owner, start after it
  always_comb begin
    pick_req = req;
    pick_ptr = ptr_reg;
    if (state_reg == GRANT) begin
      pick_req = req & ~onehot4(owner_reg);
      pick_ptr = owner_reg + 2'd1;
    end
  end

  rr_priority_pick u_pick (
    .req    (pick_req),
    .ptr    (pick_ptr),
    .winner (pick_winner),
    .any    (pick_any)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      owner_reg <= 2'd0;
      cnt_reg   <= 4'd0;
      ptr_reg   <= 2'd0;
    end else begin
      state_reg <= state_next;
      owner_reg <= owner_next;
      cnt_reg   <= cnt_next;
      ptr_reg   <= ptr_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    owner_next = owner_reg;
    cnt_next   = cnt_reg;
    ptr_next   = ptr_reg;
    case (state_reg)
      IDLE: begin
        if (pick_any) begin
          state_next = GRANT;
          owner_next = pick_winner;
          cnt_next   = CNT_LOAD;
        end
      end
      GRANT: begin
        if (grant_end) begin
          ptr_next   = owner_reg + 2'd1;
          state_next = IDLE;
`ifdef GATE_ARB_BACK_TO_BACK_EN
          if (pick_any) begin
            state_next = GRANT;
            owner_next = pick_winner;
            cnt_next   = CNT_LOAD;
          end
`endif
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    grant     = 4'b0000;
    grant_id  = 2'd0;
    grant_val = 1'b0;
    done      = 1'b0;
    if (state_reg == GRANT) begin
      grant     = onehot4(owner_reg);
      grant_id  = owner_reg;
      grant_val = 1'b1;
      done      = owner_req && (cnt_reg == 4'd0);
    end
  end

endmodule

// File: tb/tb_gate_unit_rr_arbiter.sv
// Directed-vector bench for gate_unit_rr_arbiter with HOLD_CYCLES=2.
module tb_gate_unit_rr_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic [3:0] grant;
  logic [1:0] grant_id;
  logic       grant_val;
  logic       done;

  int pass_cnt  = 0;
  int total_cnt = 0;

  typedef struct {
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] id;
    logic       val;
    logic       done;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  gate_unit_rr_arbiter #(
    .NREQ        (4),
    .HOLD_CYCLES (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .grant     (grant),
    .grant_id  (grant_id),
    .grant_val (grant_val),
    .done      (done)
  );

  function automatic void add(input logic [3:0] r, input logic [3:0] g,
                              input logic [1:0] id, input logic v, input logic d);
    vec_t e;
    e.req = r; e.grant = g; e.id = id; e.val = v; e.done = d;
    vecs.push_back(e);
  endfunction

  task automatic check(input string name, input logic [7:0] exp);
    logic [7:0] act;
    act = {grant, grant_id, grant_val, done};
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got grant=%b id=%0d val=%b done=%b, required grant=%b id=%0d val=%b done=%b",
               name, act[7:4], act[3:2], act[1], act[0], exp[7:4], exp[3:2], exp[1], exp[0]);
    end
  endtask

  initial begin
`ifdef GATE_ARB_BACK_TO_BACK_EN
    add(4'b1111, 4'b0000, 2'd0, 1'b0, 1'b0);
    add(4'b1111, 4'b0001, 2'd0, 1'b1, 1'b0);
    add(4'b1111, 4'b0001, 2'd0, 1'b1, 1'b1);
    add(4'b1111, 4'b0010, 2'd1, 1'b1, 1'b0);
    add(4'b1111, 4'b0010, 2'd1, 1'b1, 1'b1);
    add(4'b1111, 4'b0100, 2'd2, 1'b1, 1'b0);
    add(4'b1111, 4'b0100, 2'd2, 1'b1, 1'b1);
    add(4'b1111, 4'b1000, 2'd3, 1'b1, 1'b0);
    add(4'b1111, 4'b1000, 2'd3, 1'b1, 1'b1);
    add(4'b1111, 4'b0001, 2'd0, 1'b1, 1'b0);
`else
    // all requesting: owners 0,1,2,3,0 with a bubble between grants
    add(4'b1111, 4'b0000, 2'd0, 1'b0, 1'b0);
    add(4'b1111, 4'b0001, 2'd0, 1'b1, 1'b0);
    add(4'b1111, 4'b0001, 2'd0, 1'b1, 1'b1);
    add(4'b1111, 4'b0000, 2'd0, 1'b0, 1'b0);
    add(4'b1111, 4'b0010, 2'd1, 1'b1, 1'b0);
    add(4'b1111, 4'b0010, 2'd1, 1'b1, 1'b1);
    add(4'b1111, 4'b0000, 2'd0, 1'b0, 1'b0);
    add(4'b1111, 4'b0100, 2'd2, 1'b1, 1'b0);
    add(4'b1111, 4'b0100, 2'd2, 1'b1, 1'b1);
    add(4'b1111, 4'b0000, 2'd0, 1'b0, 1'b0);
    add(4'b1111, 4'b1000, 2'd3, 1'b1, 1'b0);
    add(4'b1111, 4'b1000, 2'd3, 1'b1, 1'b1);
    add(4'b1111, 4'b0000, 2'd0, 1'b0, 1'b0);
    add(4'b1111, 4'b0001, 2'd0, 1'b1, 1'b0);
    add(4'b1111, 4'b0001, 2'd0, 1'b1, 1'b1);
    // sparse requests 1010: 1, 3, 1
    add(4'b1010, 4'b0000, 2'd0, 1'b0, 1'b0);
    add(4'b1010, 4'b0010, 2'd1, 1'b1, 1'b0);
    add(4'b1010, 4'b0010, 2'd1, 1'b1, 1'b1);
    add(4'b1010, 4'b0000, 2'd0, 1'b0, 1'b0);
    add(4'b1010, 4'b1000, 2'd3, 1'b1, 1'b0);
    add(4'b1010, 4'b1000, 2'd3, 1'b1, 1'b1);
    add(4'b1010, 4'b0000, 2'd0, 1'b0, 1'b0);
    add(4'b1010, 4'b0010, 2'd1, 1'b1, 1'b0);
    add(4'b1010, 4'b0010, 2'd1, 1'b1, 1'b1);
    // single requester 0: 3-cycle repeating pattern
    add(4'b0001, 4'b0000, 2'd0, 1'b0, 1'b0);
    add(4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0);
    add(4'b0001, 4'b0001, 2'd0, 1'b1, 1'b1);
    add(4'b0001, 4'b0000, 2'd0, 1'b0, 1'b0);
    add(4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0);
    add(4'b0001, 4'b0001, 2'd0, 1'b1, 1'b1);
    // abort of requester 2, then search resumes at 3
    add(4'b0100, 4'b0000, 2'd0, 1'b0, 1'b0);
    add(4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0);
    add(4'b0000, 4'b0100, 2'd2, 1'b1, 1'b0);
    add(4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
    add(4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
    add(4'b1111, 4'b0000, 2'd0, 1'b0, 1'b0);
    add(4'b1111, 4'b1000, 2'd3, 1'b1, 1'b0);
`endif

    reset = 1'b1;
    req   = 4'b1111;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      if (i > 0) @(negedge clk);
      req = vecs[i].req;
      #1;
      $display("vec %0d req=%b grant=%b id=%0d val=%b done=%b",
               i, req, grant, grant_id, grant_val, done);
      check($sformatf("vec%0d", i),
            {vecs[i].grant, vecs[i].id, vecs[i].val, vecs[i].done});
    end

    // reset while a grant is active
    @(negedge clk);
    reset = 1'b1;
    req   = 4'b1111;
    @(negedge clk);
    reset = 1'b0;
    #1;
    $display("reset_mid grant=%b done=%b", grant, done);
    check("reset_mid", 8'b0000_00_0_0);
    @(negedge clk);
    #1;
    $display("post_reset grant=%b id=%0d", grant, grant_id);
    check("post_reset_ptr", 8'b0001_00_1_0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
